// File: rtl/aes128_dec_key_sched.sv
// Iterative AES-128 key expansion feeding a decryption core through an 11-entry round-key file.
// Optional AES_EQ_INV_KEY_EN: indices 1..9 are read out through InvMixColumns.

package aes128_dec_key_sched_pkg;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

`ifdef AES_EQ_INV_KEY_EN
   function automatic logic [127:0] inv_mix_columns(input logic [127:0] k);
      logic [127:0] r;
      logic [7:0]   a0, a1, a2, a3;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = k[127-32*c -: 8];
         a1 = k[119-32*c -: 8];
         a2 = k[111-32*c -: 8];
         a3 = k[103-32*c -: 8];
         r[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
         r[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
         r[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
         r[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
      end
      return r;
   endfunction
`endif

endpackage

// Forward S-box built from the GF(2^8) inverse (x^254) followed by the affine map.
module aes128_dec_key_sched_sbox (
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);
   import aes128_dec_key_sched_pkg::*;

   logic [7:0] inv;

   always_comb begin
      inv = in_byte;
      // x -> x^3 -> x^7 ... -> x^127, then square to x^254
      for (int i = 0; i < 6; i++) inv = gf_mul(gf_mul(inv, inv), in_byte);
      inv      = gf_mul(inv, inv);
      out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end
endmodule

module aes128_dec_key_sched #(
   parameter int NR    = 10,
   parameter int KEY_W = 128
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_valid,
   output logic             key_ready,
   input  logic [KEY_W-1:0] key_in,
   output logic             keys_ready,
   output logic             busy,
   input  logic             rd_en,
   input  logic [3:0]       rd_idx,
   output logic [KEY_W-1:0] rk_out,
   output logic             rk_valid,
   output logic             rd_err
);
`ifdef AES_EQ_INV_KEY_EN
   import aes128_dec_key_sched_pkg::*;
`endif

   if (NR != 10 || KEY_W != 128) begin : g_param_err
      $error("aes128_dec_key_sched supports only NR=10 and KEY_W=128");
   end

   localparam logic [3:0] LAST_RND = 4'(NR);

   typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_READY} state_t;

   state_t                     state_q, state_d;
   logic [3:0]                 rnd_q, rnd_d;
   logic [NR:0][KEY_W-1:0]     rk_q, rk_d;
   logic [KEY_W-1:0]           rk_out_q, rk_out_d;
   logic                       rk_valid_q, rk_valid_d;
   logic                       rd_err_q, rd_err_d;

   logic                       key_accept;
   logic                       rd_ok;
   logic [3:0]                 prev_idx;
   logic [KEY_W-1:0]           prev_rk, next_rk;
   logic [31:0]                w3_rot, w3_sub, t_word;
   logic [31:0]                nw0, nw1, nw2, nw3;
   logic [7:0]                 rcon;
   logic [KEY_W-1:0]           rd_raw, rd_sel;

   // ---------------- FSM ----------------
   always_comb begin : fsm_comb
      state_d    = state_q;
      rnd_d      = rnd_q;
      key_ready  = 1'b0;
      keys_ready = 1'b0;
      busy       = 1'b0;
      key_accept = 1'b0;
      case (state_q)
         ST_IDLE, ST_READY: begin
            key_ready  = 1'b1;
            keys_ready = (state_q == ST_READY);
            key_accept = key_valid;
            if (key_valid) begin
               state_d = ST_EXPAND;
               rnd_d   = 4'd1;
            end
         end
         ST_EXPAND: begin
            busy = 1'b1;
            if (rnd_q == LAST_RND) begin
               state_d = ST_READY;
               rnd_d   = 4'd0;
            end else begin
               rnd_d = rnd_q + 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- expansion datapath ----------------
   always_comb begin : rcon_comb
      rcon = 8'h00;
      case (rnd_q)
         4'd1:  rcon = 8'h01;
         4'd2:  rcon = 8'h02;
         4'd3:  rcon = 8'h04;
         4'd4:  rcon = 8'h08;
         4'd5:  rcon = 8'h10;
         4'd6:  rcon = 8'h20;
         4'd7:  rcon = 8'h40;
         4'd8:  rcon = 8'h80;
         4'd9:  rcon = 8'h1b;
         4'd10: rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   end

   assign prev_idx = (rnd_q == 4'd0) ? 4'd0 : rnd_q - 4'd1;
   assign prev_rk  = rk_q[prev_idx];
   assign w3_rot   = {prev_rk[23:0], prev_rk[31:24]};

   for (genvar g = 0; g < 4; g++) begin : g_sbox
      aes128_dec_key_sched_sbox u_sbox (
         .in_byte  (w3_rot[8*g +: 8]),
         .out_byte (w3_sub[8*g +: 8])
      );
   end

   assign t_word  = w3_sub ^ {rcon, 24'h000000};
   assign nw0     = prev_rk[127:96] ^ t_word;
   assign nw1     = prev_rk[95:64]  ^ nw0;
   assign nw2     = prev_rk[63:32]  ^ nw1;
   assign nw3     = prev_rk[31:0]   ^ nw2;
   assign next_rk = {nw0, nw1, nw2, nw3};

   always_comb begin : rk_comb
      rk_d = rk_q;
      if (key_accept)
         rk_d[0] = key_in;
      else if (busy)
         rk_d[rnd_q] = next_rk;
   end

   // ---------------- read port ----------------
   // A key accepted in the same cycle as a read wins; the read is rejected.
   assign rd_ok  = rd_en && keys_ready && !key_accept && (rd_idx <= LAST_RND);
   assign rd_raw = (rd_idx <= LAST_RND) ? rk_q[rd_idx] : '0;

`ifdef AES_EQ_INV_KEY_EN
   assign rd_sel = (rd_idx != 4'd0 && rd_idx != LAST_RND) ? inv_mix_columns(rd_raw) : rd_raw;
`else
   assign rd_sel = rd_raw;
`endif

   always_comb begin : rd_comb
      rk_out_d   = rk_out_q;
      rk_valid_d = rd_ok;
      rd_err_d   = rd_en && !rd_ok;
      if (rd_en) rk_out_d = rd_ok ? rd_sel : '0;
   end

   // ---------------- registers ----------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         rnd_q      <= 4'd0;
         rk_out_q   <= '0;
         rk_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         rnd_q      <= rnd_d;
         rk_out_q   <= rk_out_d;
         rk_valid_q <= rk_valid_d;
         rd_err_q   <= rd_err_d;
      end
   end

   // Register-file contents need no reset; keys_ready gates every read.
   always_ff @(posedge clk) begin
      rk_q <= rk_d;
   end

   assign rk_out   = rk_out_q;
   assign rk_valid = rk_valid_q;
   assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_aes128_dec_key_sched.sv
// Directed bench for aes128_dec_key_sched using FIPS-197 key-expansion vectors.
module tb_aes128_dec_key_sched;

   logic         clk;
   logic         rst;
   logic         key_valid;
   logic         key_ready;
   logic [127:0] key_in;
   logic         keys_ready;
   logic         busy;
   logic         rd_en;
   logic [3:0]   rd_idx;
   logic [127:0] rk_out;
   logic         rk_valid;
   logic         rd_err;

   int checks = 0;
   int errors = 0;

   localparam logic [127:0] K1      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] K1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] K2      = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] K2_RK1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
   localparam logic [127:0] K2_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   aes128_dec_key_sched dut (
      .clk        (clk),
      .rst        (rst),
      .key_valid  (key_valid),
      .key_ready  (key_ready),
      .key_in     (key_in),
      .keys_ready (keys_ready),
      .busy       (busy),
      .rd_en      (rd_en),
      .rd_idx     (rd_idx),
      .rk_out     (rk_out),
      .rk_valid   (rk_valid),
      .rd_err     (rd_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chkk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   task automatic chki(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic load_key(input logic [127:0] k);
      key_valid = 1'b1;
      key_in    = k;
      step();
      key_valid = 1'b0;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!keys_ready && n < 30) begin
         step();
         n++;
      end
      chkb("wait_keys_ready", keys_ready, 1'b1);
   endtask

   task automatic read_key(input logic [3:0] idx);
      rd_en  = 1'b1;
      rd_idx = idx;
      step();
      rd_en  = 1'b0;
   endtask

`ifdef AES_EQ_INV_KEY_EN
   function automatic logic [7:0] m(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [127:0] ref_imc(input logic [127:0] k);
      logic [127:0] r;
      logic [7:0]   b [4];
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int j = 0; j < 4; j++) b[j] = k[127-32*c-8*j -: 8];
         r[127-32*c -: 8] = m(b[0],8'h0e) ^ m(b[1],8'h0b) ^ m(b[2],8'h0d) ^ m(b[3],8'h09);
         r[119-32*c -: 8] = m(b[0],8'h09) ^ m(b[1],8'h0e) ^ m(b[2],8'h0b) ^ m(b[3],8'h0d);
         r[111-32*c -: 8] = m(b[0],8'h0d) ^ m(b[1],8'h09) ^ m(b[2],8'h0e) ^ m(b[3],8'h0b);
         r[103-32*c -: 8] = m(b[0],8'h0b) ^ m(b[1],8'h0d) ^ m(b[2],8'h09) ^ m(b[3],8'h0e);
      end
      return r;
   endfunction
`endif

   initial begin
      logic [127:0] exp_rk1;
      logic [127:0] got [11];
      logic [127:0] held;
      int           n;
      int           pulses;

      rst       = 1'b0;
      key_valid = 1'b0;
      key_in    = '0;
      rd_en     = 1'b0;
      rd_idx    = 4'd0;
      step();
      step();

      // Reset state
      chkb("rst_key_ready",  key_ready,  1'b1);
      chkb("rst_keys_ready", keys_ready, 1'b0);
      chkb("rst_busy",       busy,       1'b0);
      chkk("rst_rk_out",     rk_out,     '0);
      chkb("rst_rk_valid",   rk_valid,   1'b0);
      chkb("rst_rd_err",     rd_err,     1'b0);
      rst = 1'b1;
      step();

      // Test 1: FIPS-197 appendix A key, busy exactly 10 cycles
      load_key(K1);
      chkb("t1_key_ready_low", key_ready, 1'b0);
      n = 0;
      while (busy && n < 20) begin
         n++;
         step();
      end
      chki("t1_busy_cycles", n, 10);
      chkb("t1_keys_ready", keys_ready, 1'b1);
      chkb("t1_key_ready", key_ready, 1'b1);

`ifdef AES_EQ_INV_KEY_EN
      exp_rk1 = ref_imc(K1_RK1);
`else
      exp_rk1 = K1_RK1;
`endif
      read_key(4'd1);
      chkb("t1_rk1_valid", rk_valid, 1'b1);
      chkk("t1_rk1", rk_out, exp_rk1);
      read_key(4'd10);
      chkb("t1_rk10_valid", rk_valid, 1'b1);
      chkb("t1_rk10_err", rd_err, 1'b0);
      chkk("t1_rk10", rk_out, K1_RK10);
      held = rk_out;
      step();
      chkb("t1_idle_valid", rk_valid, 1'b0);
      chkb("t1_idle_err", rd_err, 1'b0);
      chkk("t1_idle_hold", rk_out, held);
      read_key(4'd0);
      chkk("t1_rk0", rk_out, K1);

      // Test 2: reload from READY, back-to-back reads 10..0
      load_key(K2);
      chkb("t2_busy", busy, 1'b1);
      wait_ready();
      pulses = 0;
      for (int i = 10; i >= 0; i--) begin
         rd_en  = 1'b1;
         rd_idx = 4'(i);
         step();
         if (rk_valid) pulses++;
         got[10-i] = rk_out;
      end
      rd_en = 1'b0;
      chki("t2_pulses", pulses, 11);
      chkk("t2_first_rk10", got[0], K2_RK10);
`ifdef AES_EQ_INV_KEY_EN
      chkk("t2_rk1", got[9], ref_imc(K2_RK1));
`else
      chkk("t2_rk1", got[9], K2_RK1);
`endif
      chkk("t2_last_rk0", got[10], K2);

      // Test 3: out-of-range indices in READY
      read_key(4'd11);
      chkb("t3_idx11_err", rd_err, 1'b1);
      chkb("t3_idx11_valid", rk_valid, 1'b0);
      chkk("t3_idx11_out", rk_out, '0);
      read_key(4'd10);
      chkk("t3_idx10_ok", rk_out, K2_RK10);
      read_key(4'd15);
      chkb("t3_idx15_err", rd_err, 1'b1);
      chkb("t3_idx15_valid", rk_valid, 1'b0);
      chkk("t3_idx15_out", rk_out, '0);

      // Test 4: key accept and read collide; then read during EXPAND
      read_key(4'd1);
      key_valid = 1'b1;
      key_in    = K1;
      rd_en     = 1'b1;
      rd_idx    = 4'd3;
      step();
      key_valid = 1'b0;
      rd_idx    = 4'd0;
      chkb("t4_coll_err", rd_err, 1'b1);
      chkb("t4_coll_valid", rk_valid, 1'b0);
      chkk("t4_coll_out", rk_out, '0);
      chkb("t4_keys_ready", keys_ready, 1'b0);
      chkb("t4_busy", busy, 1'b1);
      step();
      rd_en = 1'b0;
      chkb("t4_expand_err", rd_err, 1'b1);
      chkb("t4_expand_valid", rk_valid, 1'b0);
      wait_ready();
      read_key(4'd10);
      chkk("t4_new_rk10", rk_out, K1_RK10);

      // Test 5: reset in the 5th EXPAND cycle
      load_key(K2);
      for (int i = 0; i < 4; i++) step();
      chkb("t5_still_busy", busy, 1'b1);
      rst = 1'b0;
      step();
      rst = 1'b1;
      chkb("t5_busy", busy, 1'b0);
      chkb("t5_keys_ready", keys_ready, 1'b0);
      chkb("t5_key_ready", key_ready, 1'b1);
      step();
      chkb("t5_stays_idle", keys_ready, 1'b0);
      read_key(4'd0);
      chkb("t5_idle_read_err", rd_err, 1'b1);
      load_key(K2);
      wait_ready();
      read_key(4'd10);
      chkk("t5_rk10", rk_out, K2_RK10);
      read_key(4'd0);
      chkk("t5_rk0", rk_out, K2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
